// File: rtl/ro_freq_pkg.sv
// ro_freq_pkg: shared FSM encoding and default widths for the ring-oscillator frequency reader
package ro_freq_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_WIN_W = 16;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/osc_edge_sync.sv
// osc_edge_sync: multi-flop synchronizer for the async oscillator plus a registered rising-edge detector
module osc_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], osc};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
endmodule

// File: rtl/ro_freq_reader.sv
// ro_freq_reader: counts synchronized ring-oscillator edges over a programmable CLK window
module ro_freq_reader
  import ro_freq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc,
  input  logic             start,
  input  logic [WIN_W-1:0] win,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  localparam logic [WIN_W-1:0] ARM_LAST = WIN_W'(SYNC_STAGES);
  state_t state;
  logic [WIN_W-1:0] win_q, wcnt;
  logic rise;
  osc_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .osc(osc), .rise(rise));
  // wcnt counts down to zero in both ARM (SYNC_STAGES+1 cycles) and MEAS (win cycles)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
      win_q <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start && win != '0) begin
          win_q <= win;
          wcnt  <= ARM_LAST;
          count <= '0;
          ovf   <= 1'b0;
          busy  <= 1'b1;
          state <= ARM;
        end
        ARM: if (wcnt == '0) begin
          wcnt  <= win_q - 1'b1;
          state <= MEAS;
        end else wcnt <= wcnt - 1'b1;
        MEAS: begin
          if (rise) begin
            if (&count) ovf <= 1'b1;
            else count <= count + 1'b1;
          end
          if (wcnt == '0) begin
            valid <= 1'b1;
            state <= HOLD;
          end else wcnt <= wcnt - 1'b1;
        end
        HOLD: if (ack) begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ro_freq_reader.sv
// tb_ro_freq_reader: scoreboard bench with directed measurements on default and 4-bit-count instances
module tb_ro_freq_reader;
  logic clk = 0, rst = 1, osc_a = 0, osc_b = 0, osc_lvl = 0;
  logic start = 0, ack = 0, start_b = 0, ack_b = 0;
  logic [15:0] win = 0, win_b = 0;
  logic busy, valid, ovf, busy_b, valid_b, ovf_b;
  logic [15:0] count;
  logic [3:0] count_b;
  int checks = 0, errors = 0, cyc = 0, osc_mode = 0;
  logic seen = 0, seen_b = 0;
  typedef struct {int lo; int hi; logic o; int at;} exp_t;
  exp_t sb[$], sb_b[$];

  ro_freq_reader dut (.clk(clk), .rst(rst), .osc(osc_a), .start(start), .win(win), .busy(busy),
                      .valid(valid), .ack(ack), .count(count), .ovf(ovf));
  ro_freq_reader #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .osc(osc_b), .start(start_b), .win(win_b),
                      .busy(busy_b), .valid(valid_b), .ack(ack_b), .count(count_b), .ovf(ovf_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // oscillators change only on CLK falling edges: CLK/4 (or a held level) and CLK/2
  initial forever begin #20; osc_a = (osc_mode == 1) ? ~osc_a : osc_lvl; end
  initial forever begin #10; osc_b = ~osc_b; end

  task automatic chk(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
    end
  endtask

  task automatic cmp(string tag, exp_t e, int cnt, logic o);
    chk({tag, "_count"}, cnt, e.lo, e.hi);
    chk({tag, "_ovf"}, int'(o), int'(e.o), int'(e.o));
    chk({tag, "_latency"}, cyc, e.at, e.at);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid && !seen) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0, 0);
      else begin e = sb.pop_front(); cmp("main", e, int'(count), ovf); end
    end
    if (valid_b && !seen_b) begin
      if (sb_b.size() == 0) chk("unexpected_valid_b", 1, 0, 0);
      else begin e = sb_b.pop_front(); cmp("cnt4", e, int'(count_b), ovf_b); end
    end
    seen <= valid;
    seen_b <= valid_b;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(int w, int lo, int hi, logic o);
    sb.push_back('{lo, hi, o, cyc + 1 + 3 + w});
    win = 16'(w);
    start = 1;
    tick(1);
    start = 0;
    win = 16'd7;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 3000) begin tick(1); n++; end
    if (!valid) chk("wait_valid_timeout", 0, 1, 1);
  endtask

  task automatic consume();
    ack = 1;
    tick(1);
    ack = 0;
  endtask

  initial begin
    int n, c, bad;
    tick(2);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_valid", int'(valid), 0, 0);
    chk("rst_count", int'(count), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    rst = 0;
    tick(2);
    osc_mode = 1;
    tick(4);
    issue(100, 25, 25, 0);
    chk("busy_on_accept", int'(busy), 1, 1);
    wait_valid();
    consume();
    chk("busy_after_ack", int'(busy), 0, 0);
    sb_b.push_back('{15, 15, 1'b1, cyc + 1 + 3 + 64});
    win_b = 16'd64;
    start_b = 1;
    tick(1);
    start_b = 0;
    n = 0;
    while (!valid_b && n < 3000) begin tick(1); n++; end
    if (!valid_b) chk("wait_valid_b_timeout", 0, 1, 1);
    ack_b = 1;
    tick(1);
    ack_b = 0;
    win = 16'd0;
    start = 1;
    tick(1);
    start = 0;
    chk("win0_busy", int'(busy), 0, 0);
    tick(8);
    chk("win0_valid", int'(valid), 0, 0);
    issue(10, 2, 3, 0);
    wait_valid();
    consume();
    issue(100, 0, 0, 0);
    tick(53);
    sb.delete();
    rst = 1;
    #1;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_valid", int'(valid), 0, 0);
    chk("abort_count", int'(count), 0, 0);
    chk("abort_ovf", int'(ovf), 0, 0);
    tick(1);
    rst = 0;
    tick(1);
    issue(100, 25, 25, 0);
    wait_valid();
    consume();
    chk("count_kept_after_ack", int'(count), 25, 25);
    issue(30, 7, 8, 0);
    wait_valid();
    c = int'(count);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin win = 16'd5; start = 1; end
      tick(1);
      start = 0;
      if (!valid || int'(count) != c) bad++;
    end
    chk("hold_stable", bad, 0, 0);
    start = 1;
    consume();
    start = 0;
    chk("hold_exit_valid", int'(valid), 0, 0);
    chk("hold_exit_busy", int'(busy), 0, 0);
    chk("hold_exit_count", int'(count), c, c);
    tick(10);
    chk("no_restart", int'(busy), 0, 0);
    osc_mode = 0;
    osc_lvl = 1;
    tick(10);
    issue(50, 0, 0, 0);
    wait_valid();
    consume();
    tick(5);
    chk("sb_drained", sb.size() + sb_b.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
